disp_hole_fill: RTL and testbench



---
 rtl/stereo_pkg.sv | 24 ++
 rtl/hole_fill_fifo.sv | 50 +++++
 rtl/disp_hole_fill.sv | 170 +++++++++++++++++
 tb/tb_disp_hole_fill.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared stereo constants and the hole-fill delay-stage record.
package stereo_pkg;

  localparam int DISP_W = 8;
  localparam int MAX_DISP = 64;
  localparam logic [DISP_W-1:0] INVALID_DISP = '0;
  localparam int LRC_T = 8;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DISP_W-1:0] data;
    logic              run_first;
    logic [DISP_W-1:0] left_val;
    logic              left_ok;
    logic              resolved;
  } hf_stage_t;

  function automatic logic [DISP_W-1:0] min_disp(input logic [DISP_W-1:0] a,
                                                 input logic [DISP_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hole_fill_fifo.sv
// rtl/hole_fill_fifo.sv - synchronous FIFO of resolved run fill values.
module hole_fill_fifo #(
  parameter int DEPTH = 5,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/disp_hole_fill.sv
// rtl/disp_hole_fill.sv - scanline hole filler, min(left,right) background fill, latency D+1.
// Optional per-line filled-pixel counter under HOLE_FILL_STATS_EN.
module disp_hole_fill
  import stereo_pkg::*;
#(
  parameter int DISP_W     = stereo_pkg::DISP_W,
  parameter int D          = 16,
  parameter int FIFO_DEPTH = D / 2 + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] disp_in,
  input  logic              disp_in_valid,
  input  logic              disp_in_last,
  output logic [DISP_W-1:0] disp_out,
  output logic              disp_out_valid,
`ifdef HOLE_FILL_STATS_EN
  output logic [15:0]       hole_cnt,
  output logic              hole_cnt_valid,
`endif
  output logic              disp_out_last
);

  localparam int AW = $clog2(D + 1);
  localparam logic [AW-1:0] D_AGE = AW'(D);

  hf_stage_t         pipe     [D];
  hf_stage_t         pipe_nxt [D];
  hf_stage_t         in_stage, s;
  logic              in_run, left_ok, run_left_ok;
  logic [DISP_W-1:0] left_val, run_left_val, push_fill, fill, hold_fill, fifo_head;
  logic [AW-1:0]     age, close_idx;
  logic              in_zero, first, tracking, push, pop, fifo_empty, fifo_full;

  always_comb begin
    in_zero   = (disp_in == INVALID_DISP);
    first     = disp_in_valid && in_zero && !in_run;
    tracking  = in_run && (age < D_AGE);
    close_idx = first ? '0 : age;
    push      = 1'b0;
    push_fill = '0;
    if (disp_in_valid) begin
      if (!in_zero && tracking) begin
        push      = 1'b1;
        push_fill = run_left_ok ? min_disp(run_left_val, disp_in) : disp_in;
      end else if (in_zero && disp_in_last && first) begin
        push      = 1'b1;
        push_fill = left_ok ? left_val : '0;
      end else if (in_zero && disp_in_last && tracking) begin
        push      = 1'b1;
        push_fill = run_left_ok ? run_left_val : '0;
      end
    end
    in_stage           = '0;
    in_stage.valid     = disp_in_valid;
    in_stage.last      = disp_in_last;
    in_stage.data      = disp_in;
    in_stage.run_first = first;
    in_stage.left_val  = left_val;
    in_stage.left_ok   = left_ok;
    pipe_nxt[0] = in_stage;
    for (int i = 1; i < D; i++) pipe_nxt[i] = pipe[i-1];
    // A run closing at age k has its first pixel moving into stage k this edge.
    for (int i = 0; i < D; i++) begin
      if (push && close_idx == AW'(i)) pipe_nxt[i].resolved = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) pipe[i] <= '0;
      in_run       <= 1'b0;
      left_ok      <= 1'b0;
      left_val     <= '0;
      run_left_ok  <= 1'b0;
      run_left_val <= '0;
      age          <= '0;
    end else begin
      pipe <= pipe_nxt;
      if (first) age <= AW'(1);
      else if (in_run && age < D_AGE) age <= age + 1'b1;
      if (disp_in_valid) begin
        if (!in_zero) begin
          in_run   <= 1'b0;
          left_val <= disp_in;
          left_ok  <= !disp_in_last;
        end else if (disp_in_last) begin
          in_run  <= 1'b0;
          left_ok <= 1'b0;
        end else if (first) begin
          in_run       <= 1'b1;
          run_left_val <= left_val;
          run_left_ok  <= left_ok;
        end
      end
    end
  end

  hole_fill_fifo #(.DEPTH(FIFO_DEPTH), .W(DISP_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_fill),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full));
  end

  assign s = pipe[D-1];

  always_comb begin
    pop  = 1'b0;
    fill = hold_fill;
    if (s.valid && s.data == INVALID_DISP && s.run_first) begin
      if (s.resolved) begin
        pop  = !fifo_empty;
        fill = fifo_head;
      end else begin
        fill = s.left_ok ? s.left_val : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_out       <= '0;
      disp_out_valid <= 1'b0;
      disp_out_last  <= 1'b0;
      hold_fill      <= '0;
    end else begin
      disp_out_valid <= s.valid;
      disp_out_last  <= s.valid && s.last;
      if (s.valid) begin
        if (s.data != INVALID_DISP) begin
          disp_out <= s.data;
        end else begin
          disp_out  <= fill;
          hold_fill <= fill;
        end
      end
    end
  end

`ifdef HOLE_FILL_STATS_EN
  logic [15:0] cnt_acc, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_acc;
    if (s.valid && s.data == INVALID_DISP && cnt_acc != 16'hFFFF) cnt_nxt = cnt_acc + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_acc        <= '0;
      hole_cnt       <= '0;
      hole_cnt_valid <= 1'b0;
    end else begin
      hole_cnt_valid <= s.valid && s.last;
      hole_cnt       <= (s.valid && s.last) ? cnt_nxt : 16'd0;
      if (s.valid) cnt_acc <= s.last ? 16'd0 : cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_disp_hole_fill.sv
// tb/tb_disp_hole_fill.sv - scoreboard bench for disp_hole_fill with D=8.
module tb_disp_hole_fill;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] disp_in = '0;
  logic       disp_in_valid = 1'b0;
  logic       disp_in_last = 1'b0;
  logic [7:0] disp_out;
  logic       disp_out_valid;
  logic       disp_out_last;
`ifdef HOLE_FILL_STATS_EN
  logic [15:0] hole_cnt;
  logic        hole_cnt_valid;
`endif

  disp_hole_fill #(.DISP_W(8), .D(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_in       (disp_in),
    .disp_in_valid (disp_in_valid),
    .disp_in_last  (disp_in_last),
    .disp_out      (disp_out),
    .disp_out_valid(disp_out_valid),
`ifdef HOLE_FILL_STATS_EN
    .hole_cnt      (hole_cnt),
    .hole_cnt_valid(hole_cnt_valid),
`endif
    .disp_out_last (disp_out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cnt_q[$];
  int   line_holes = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send(input int v, input bit last, input int e);
    exp_t x;
    @(posedge clk);
    #1;
    disp_in       = v[7:0];
    disp_in_valid = 1'b1;
    disp_in_last  = last;
    x.data = e;
    x.last = last;
    x.cyc  = cyc + D + 1;
    q.push_back(x);
    if (v == 0) line_holes++;
    if (last) begin
      cnt_q.push_back(line_holes);
      line_holes = 0;
    end
  endtask

  task automatic zeros(input int n, input int e);
    for (int i = 0; i < n; i++) send(0, 1'b0, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      disp_in_valid = 1'b0;
      disp_in_last  = 1'b0;
      disp_in       = '0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && disp_out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        check("data", int'(disp_out), e.data);
        check("last", int'(disp_out_last), int'(e.last));
        check("latency_cycle", cyc, e.cyc);
`ifdef HOLE_FILL_STATS_EN
        if (e.last && cnt_q.size() > 0) begin
          check("hole_cnt_valid", int'(hole_cnt_valid), 1);
          check("hole_cnt", int'(hole_cnt), cnt_q.pop_front());
        end
`endif
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", int'(disp_out), 0);
    check("reset_valid", int'(disp_out_valid), 0);
    check("reset_last", int'(disp_out_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    send(10, 0, 10); send(0, 0, 10); send(0, 0, 10); send(20, 1, 20);
    send(30, 0, 30); send(0, 0, 5); send(5, 1, 5);
    send(0, 0, 7); send(0, 0, 7); send(7, 1, 7);
    send(12, 0, 12); send(0, 0, 12); send(0, 0, 12); send(0, 1, 12);
    send(9, 0, 9); zeros(12, 9); send(4, 1, 4);
    send(40, 0, 40); zeros(7, 15); send(15, 1, 15);
    send(40, 0, 40); zeros(8, 40); send(15, 1, 15);
    send(50, 0, 50); send(0, 0, 8); send(8, 0, 8); send(0, 0, 8);
    send(60, 0, 60); send(0, 0, 3); send(3, 1, 3);
    send(25, 0, 25); send(0, 0, 25); idle(10); send(20, 1, 20);
    send(0, 0, 0); send(0, 0, 0); send(0, 1, 0);
    idle(D + 4);

    send(2, 0, 2); send(0, 0, 2); send(0, 0, 2);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    disp_in_valid = 1'b0;
    disp_in_last  = 1'b0;
    q.delete();
    line_holes = 0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_out", int'(disp_out), 0);
    check("midreset_valid", int'(disp_out_valid), 0);
    check("midreset_last", int'(disp_out_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 0, 7); send(0, 0, 7); send(7, 1, 7);
    idle(1);

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain_pending", q.size(), 0);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
